// File: rtl/quat_pkg.sv
// Shared types and helpers for the quaternion operand FIFO.
// Provides the identity-quaternion word builder and the pointer/count width
// helpers. The optional QSFIFO_STATS_EN feature is handled in the FIFO files.
package quat_pkg;

  // One quaternion occupies four consecutive lanes (real part in lane 0).
  localparam int QUAT_LANES = 4;

  // Widest lane the identity helper can describe; callers slice it down.
  localparam int QLANE_W = 32;

  typedef logic [QLANE_W-1:0] qlane_t;
  typedef qlane_t [QUAT_LANES-1:0] qword_t;

  // Push/pop combination seen by the controller in one cycle.
  typedef enum logic [1:0] {
    QF_IDLE = 2'b00,
    QF_POP  = 2'b01,
    QF_PUSH = 2'b10,
    QF_BOTH = 2'b11
  } qf_op_e;

  // Identity quaternion 1 + 0i + 0j + 0k: real lane carries one_val.
  function automatic qword_t quat_identity(input qlane_t one_val);
    qword_t w;
    w    = '0;
    w[0] = one_val;
    return w;
  endfunction

  // Read/write pointer width; a single-entry FIFO still needs one bit.
  function automatic int qf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so the full value DEPTH is representable.
  function automatic int qf_cnt_w(input int depth);
    return qf_ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/quat_stream_fifo_ctrl.sv
// Control path of the quaternion operand FIFO: pointers, occupancy,
// push/pop/flush arbitration and status flags.
// Optional high-water mark under QSFIFO_STATS_EN.
module qfifo_ctrl
  import quat_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
`ifdef QSFIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int PTR_W = qf_ptr_w(DEPTH);
  localparam int CNT_W = qf_cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   push, pop;
  qf_op_e op;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AFULL_CNT);
  assign count       = count_q;
  assign wr_ptr      = wr_ptr_q;
  assign rd_ptr      = rd_ptr_q;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  // A flushed beat never lands in storage.
  assign wr_en = push & ~flush;
  assign op    = qf_op_e'({push, pop});

  // Next-state: flush overrides any transfer; pointers wrap at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        QF_PUSH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        QF_POP: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
        QF_BOTH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef QSFIFO_STATS_EN
  logic [CNT_W-1:0] max_level_q, max_level_d;

  assign max_level_d = (count_d > max_level_q) ? count_d : max_level_q;
  assign max_level   = max_level_q;

  // High-water mark tracks the next occupancy; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end
`endif

endmodule

// File: rtl/quat_stream_fifo.sv
// Quaternion operand FIFO between the operand loader and the multiplier.
// First-word-fall-through storage with an identity-quaternion output when empty.
// Define QSFIFO_STATS_EN to add the max_level high-water-mark port.
module quat_stream_fifo
  import quat_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LANES        = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6,
  parameter int ONE_VAL      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
`ifdef QSFIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]  max_level
`endif
);

  localparam int     PTR_W   = qf_ptr_w(DEPTH);
  localparam qword_t ID_WORD = quat_identity(qlane_t'(ONE_VAL));

  logic [LANES*DATA_W-1:0] mem_q [DEPTH];
  logic [LANES*DATA_W-1:0] ident;
  logic                    wr_en;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  qfifo_ctrl #(
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .wr_en      (wr_en),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .almost_full(almost_full)
`ifdef QSFIFO_STATS_EN
    ,
    .max_level  (max_level)
`endif
  );

  // Identity pattern: real lane of each quaternion = ONE_VAL, imaginary lanes = 0.
  for (genvar k = 0; k < LANES; k++) begin : g_ident
    assign ident[k*DATA_W +: DATA_W] = ID_WORD[k % QUAT_LANES][DATA_W-1:0];
  end

  // Storage is data-only and deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  // Head entry falls through combinationally; identity whenever nothing is valid.
  assign out_data = out_valid ? mem_q[rd_ptr] : ident;

endmodule

// File: tb/tb_quat_stream_fifo.sv
// Self-checking bench for quat_stream_fifo (default parameters).
// Build with QSFIFO_STATS_EN defined to also exercise max_level.
module tb_quat_stream_fifo;

  localparam int DATA_W = 16;
  localparam int LANES  = 8;
  localparam int DEPTH  = 8;
  localparam int W      = DATA_W * LANES;

  localparam logic [W-1:0] IDENT_LIT = 128'h0000_0000_0000_0001_0000_0000_0000_0001;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   count;
  logic         almost_full;
`ifdef QSFIFO_STATS_EN
  logic [3:0]   max_level;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] mq[$];
  int           m_max = 0;

  always #5 clk = ~clk;

  quat_stream_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .almost_full(almost_full)
`ifdef QSFIFO_STATS_EN
    ,
    .max_level  (max_level)
`endif
  );

  function automatic logic [W-1:0] ident_rule();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = (k % 4 == 0) ? 16'd1 : 16'd0;
    return r;
  endfunction

  // Lane 0 carries v; other lanes are tagged with their lane number.
  function automatic logic [W-1:0] beat(input int v);
    logic [W-1:0] b;
    for (int k = 0; k < LANES; k++) b[k*DATA_W +: DATA_W] = 16'((k << 12) | (v & 'hfff));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of beats plus a high-water mark.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_max = 0;
    end else begin
      bit p, q;
      p = in_valid && (mq.size() < DEPTH);
      q = out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (q) void'(mq.pop_front());
        if (p) mq.push_back(in_data);
      end
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", W'(count), W'(mq.size()));
      chk("in_ready", W'(in_ready), W'(mq.size() != DEPTH));
      chk("out_valid", W'(out_valid), W'(mq.size() != 0));
      chk("almost_full", W'(almost_full), W'(mq.size() >= 6));
      chk("out_data", out_data, (mq.size() != 0) ? mq[0] : ident_rule());
`ifdef QSFIFO_STATS_EN
      chk("max_level", W'(max_level), W'(m_max));
`endif
    end
  end

  initial begin
    #2 reset = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;

    // T1: reset in the middle of traffic
    chk("t1_ident_rule", ident_rule(), IDENT_LIT);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = beat(i);
      step();
    end
    in_valid = 1'b0;
    chk("t1_count3", W'(count), W'(3));
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_count", W'(count), W'(0));
    chk("t1_rst_out_valid", W'(out_valid), W'(0));
    chk("t1_rst_in_ready", W'(in_ready), W'(1));
    chk("t1_rst_afull", W'(almost_full), W'(0));
    chk("t1_rst_out_data", out_data, IDENT_LIT);
    step();
    reset = 1'b0;

    // T2: fill then drain in order
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = beat(i);
      step();
      chk("t2_count", W'(count), W'(i + 1));
      chk("t2_afull", W'(almost_full), W'((i + 1) >= 6));
    end
    in_valid = 1'b0;
    chk("t2_in_ready_full", W'(in_ready), W'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_lane0", W'(out_data[15:0]), W'(i));
      step();
    end
    out_ready = 1'b0;
    chk("t2_empty", W'(count), W'(0));

    // T3: simultaneous push/pop at count 4 across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = beat(10 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = beat(20 + i);
      chk("t3_head", W'(out_data[15:0]), W'((i < 4) ? (10 + i) : (16 + i)));
      step();
      chk("t3_count", W'(count), W'(4));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_tail", W'(out_data[15:0]), W'(26 + i));
      step();
    end
    out_ready = 1'b0;

    // T4: full with a simultaneous offer and pop
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = beat(40 + i);
      step();
    end
    in_data   = beat(99);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t4_count7", W'(count), W'(7));
    chk("t4_head", W'(out_data[15:0]), W'(41));
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t4_drain", W'(out_data[15:0]), W'(41 + i));
      step();
    end
    out_ready = 1'b0;
    chk("t4_empty", W'(count), W'(0));

    // T5: flush wins over a same-cycle push
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = beat(50 + i);
      step();
    end
    flush   = 1'b1;
    in_data = beat(77);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_count", W'(count), W'(0));
    chk("t5_out_valid", W'(out_valid), W'(0));
    chk("t5_out_data", out_data, IDENT_LIT);
    in_valid = 1'b1;
    in_data  = beat(60);
    step();
    in_valid = 1'b0;
    chk("t5_after_count", W'(count), W'(1));
    chk("t5_after_head", out_data, beat(60));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef QSFIFO_STATS_EN
    // T6: high-water mark survives drain and flush, cleared by reset
    #2 reset = 1'b1;
    #1;
    chk("t6_max_rst", W'(max_level), W'(0));
    step();
    reset    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = beat(70 + i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_max_kept", W'(max_level), W'(6));
    #2 reset = 1'b1;
    #1;
    chk("t6_max_cleared", W'(max_level), W'(0));
    step();
    reset = 1'b0;
`endif

    step();
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
